// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 3x4 keypad row scanner with debounced key-code latch and level interrupt.
// Define KEYPAD_REPEAT_EN to emit auto-repeat events while a key stays held.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       C,
  input  logic       A,
  input  logic       E,
  input  logic       INTR_ACK,
  output logic       B,
  output logic       G,
  output logic       F,
  output logic       D,
  output logic [3:0] KEY_CODE,
  output logic       INTR
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    meta_q, col_q;
  logic [DW-1:0] div_q;
  logic [1:0]    row_q, row_d;
  logic [2:0]    cap_q, cap_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    code_q, code_d, key_map;
  logic          intr_q, intr_d;
  logic          tick, col_zero, one_hot, match, press_ev, rpt_ev, key_ev;

  assign tick     = div_q == DIV_LAST;
  assign col_zero = col_q == 3'b000;
  assign one_hot  = $onehot(col_q);
  assign match    = col_q == cap_q;
  assign cnt_inc  = cnt_q + 1'b1;
  assign key_ev   = press_ev | rpt_ev;
  // Bottom row is irregular (* 0 #); the others are 3*row + column + 1.
  assign key_map  = row_q == 2'd3 ? (col_q[2] ? 4'hA : col_q[1] ? 4'h0 : 4'hB)
                  : {2'b00, row_q} * 4'd3 + (col_q[2] ? 4'd1 : col_q[1] ? 4'd2 : 4'd3);

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= SCAN;
    else        state_q <= state_d;

  always_comb begin
    state_d  = state_q;
    press_ev = 1'b0;
    if (tick)
      case (state_q)
        SCAN: if (one_hot) begin
          press_ev = DEBOUNCE_CNT == 1;
          state_d  = press_ev ? HELD : DEBOUNCE;
        end
        DEBOUNCE: begin
          press_ev = match && cnt_inc == DB_LAST;
          state_d  = !match ? SCAN : press_ev ? HELD : DEBOUNCE;
        end
        HELD:    state_d = col_zero && cnt_inc == DB_LAST ? SCAN : HELD;
        default: state_d = SCAN;
      endcase
  end

  always_comb begin
    row_d  = tick && state_d == SCAN ? row_q + 2'd1 : row_q;
    cap_d  = tick && state_q == SCAN && one_hot ? col_q : cap_q;
    cnt_d  = !tick                ? cnt_q
           : state_q == SCAN      ? (one_hot && !press_ev ? CW'(1) : '0)
           : state_q == DEBOUNCE  ? (match && !press_ev ? cnt_inc : '0)
           : (col_zero && state_d == HELD ? cnt_inc : '0);
    code_d = key_ev ? key_map : code_q;
    intr_d = key_ev | (intr_q & ~INTR_ACK);
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      meta_q <= '0;
      col_q  <= '0;
      div_q  <= '0;
      row_q  <= '0;
      cap_q  <= '0;
      cnt_q  <= '0;
      code_q <= '0;
      intr_q <= 1'b0;
    end else begin
      meta_q <= {C, A, E};
      col_q  <= meta_q;
      div_q  <= tick ? '0 : div_q + 1'b1;
      row_q  <= row_d;
      cap_q  <= cap_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
      intr_q <= intr_d;
    end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS);
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
  assign rpt_inc = rpt_q + 1'b1;
  assign rpt_ev  = state_q == HELD && tick && match && rpt_inc == RPT_LAST;
  assign rpt_d   = state_q != HELD ? '0 : !tick ? rpt_q : (!match || rpt_ev) ? '0 : rpt_inc;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) rpt_q <= '0;
    else        rpt_q <= rpt_d;
`else
  assign rpt_ev = 1'b0;
`endif

  always_comb begin
    {D, F, G, B} = 4'b0001 << row_q;
    KEY_CODE     = code_q;
    INTR         = intr_q;
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad matrix model driving keypad_scan_ctrl; key events checked against a scoreboard queue.
module tb_keypad_scan_ctrl;
  logic       CLK = 1'b0, RST_N = 1'b0, INTR_ACK = 1'b0;
  logic       C, A, E, B, G, F, D, INTR;
  logic [3:0] KEY_CODE, drv;
  logic [2:0] keys [4];
  logic [2:0] colv;
  logic [3:0] exp_q [$];
  int         checks = 0, errors = 0;
  logic       p_intr;
  logic [3:0] p_code;
  int         code_tbl [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_TICKS(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .C(C), .A(A), .E(E), .INTR_ACK(INTR_ACK),
    .B(B), .G(G), .F(F), .D(D), .KEY_CODE(KEY_CODE), .INTR(INTR)
  );

  always #5 CLK = ~CLK;
  assign drv = {D, F, G, B};

  always_comb begin
    colv = 3'b000;
    for (int r = 0; r < 4; r++) if (drv[r]) colv |= keys[r];
  end
  assign {C, A, E} = colv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // An event is a rising INTR or a KEY_CODE change while INTR is already high.
  always @(negedge CLK) begin
    if (!RST_N) begin
      p_intr = 1'b0;
      p_code = 4'h0;
    end else begin
      if ((INTR && !p_intr) || KEY_CODE !== p_code) begin
        chk("evt_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("evt_code", KEY_CODE, exp_q.pop_front());
      end
      p_intr = INTR;
      p_code = KEY_CODE;
    end
  end

  task automatic press(input int r, input int j);
    exp_q.push_back(4'(code_tbl[r][j]));
    keys[r] = 3'b100 >> j;
  endtask

  task automatic wait_intr(input string tag, input int maxc);
    int n = 0;
    while (INTR !== 1'b1 && n < maxc) begin @(negedge CLK); n++; end
    chk(tag, INTR, 1);
  endtask

  task automatic wait_code(input string tag, input logic [3:0] code, input int maxc);
    int n = 0;
    while (KEY_CODE !== code && n < maxc) begin @(negedge CLK); n++; end
    chk(tag, KEY_CODE, code);
  endtask

  task automatic wait_row_leave(input string tag, input int r, input int maxc);
    int n = 0;
    while (drv[r] === 1'b1 && n < maxc) begin @(negedge CLK); n++; end
    chk(tag, drv[r], 0);
  endtask

  task automatic ack_pulse(input string tag);
    INTR_ACK = 1'b1;
    @(negedge CLK);
    INTR_ACK = 1'b0;
    chk(tag, INTR, 0);
  endtask

  initial begin
    int ev, n_exp;
    logic [3:0] seen;
    for (int r = 0; r < 4; r++) keys[r] = 3'b000;
    #3;
    chk("rst_rows", drv, 4'b0001);
    chk("rst_code", KEY_CODE, 0);
    chk("rst_intr", INTR, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge CLK);
      chk("rotate", drv, 4'b0001 << ((k / 4) % 4));
      chk("idle_out", {INTR, KEY_CODE}, 0);
    end

    press(1, 1);
    wait_intr("k5_intr", 100);
    chk("k5_code", KEY_CODE, 5);
    chk("k5_frozen", drv, 4'b0010);
    repeat (8) @(negedge CLK);
    chk("k5_frozen2", drv, 4'b0010);
    ack_pulse("k5_ack");
    chk("k5_code_hold", KEY_CODE, 5);
    keys[1] = 3'b000;
    repeat (6) @(negedge CLK);
    chk("k5_rel_frozen", drv, 4'b0010);
    wait_row_leave("k5_rel", 1, 40);
    chk("k5_rel_adv", drv, 4'b0100);

    exp_q.push_back(4'hB);
    for (int i = 0; i < 6; i++) begin
      keys[3] = (i % 2 == 0) ? 3'b001 : 3'b000;
      repeat (4) @(negedge CLK);
    end
    keys[3] = 3'b001;
    wait_intr("bnc_intr", 100);
    chk("bnc_code", KEY_CODE, 4'hB);
    ack_pulse("bnc_ack");
    keys[3] = 3'b000;
    wait_row_leave("bnc_rel", 3, 60);

    keys[0] = 3'b101;
    seen = 4'b0000;
    repeat (64) begin
      @(negedge CLK);
      seen |= drv;
    end
    chk("ghost_rot", seen, 4'hF);
    chk("ghost_intr", INTR, 0);
    keys[0] = 3'b000;

    press(2, 0);
    wait_intr("k7_intr", 100);
    keys[2] = 3'b000;
    wait_row_leave("k7_rel", 2, 60);
    press(3, 1);
    wait_code("k0_code", 4'h0, 100);
    chk("k0_intr_held", INTR, 1);
    keys[3] = 3'b000;
    wait_row_leave("k0_rel", 3, 60);
    ack_pulse("k0_ack");

    INTR_ACK = 1'b1;
    press(2, 2);
    wait_intr("ackev_intr", 100);
    chk("ackev_code", KEY_CODE, 9);
    @(negedge CLK);
    chk("ackev_clr", INTR, 0);
    INTR_ACK = 1'b0;
    keys[2] = 3'b000;
    wait_row_leave("ackev_rel", 2, 60);

`ifdef KEYPAD_REPEAT_EN
    n_exp = 4;
`else
    n_exp = 1;
`endif
    for (int i = 1; i < n_exp; i++) exp_q.push_back(4'h1);
    press(0, 0);
    wait_intr("rpt_first", 100);
    ev = 1;
    INTR_ACK = 1'b1;
    repeat (68) begin
      @(negedge CLK);
      if (INTR_ACK) INTR_ACK = 1'b0;
      else if (INTR) begin
        ev++;
        INTR_ACK = 1'b1;
      end
    end
    INTR_ACK = 1'b0;
    chk("rpt_events", ev, n_exp);
    chk("rpt_code", KEY_CODE, 1);
    keys[0] = 3'b000;
    wait_row_leave("rpt_rel", 0, 60);

    press(1, 1);
    wait_intr("rst_pre_intr", 100);
    chk("rst_pre_held", drv, 4'b0010);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_rows", drv, 4'b0001);
    chk("mid_rst_intr", INTR, 0);
    chk("mid_rst_code", KEY_CODE, 0);
    keys[1] = 3'b000;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);
    chk("post_rst_intr", INTR, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
